anita_event_buffer_sched: RTL

//  Write-side scheduler and occupancy tracker for the event buffer RAM (NBUF x WORDS x 16b).
//  - Allocates buffers to incoming events in strict order.
//  - Sequences the 16-bit word writes and pulses event_done_o when an event is complete.
//  - Owns the read pointer, advanced by clear_evt_i, so the readout path always sees events in FIFO order.
//  - Sits between trigger/digitizer capture and the buffer RAM + readout logic; all on clk33.

---
 rtl/anita_evbuf_pkg.sv | 18 +
 rtl/anita_event_buffer_sched_if.sv | 33 +++
 rtl/anita_evbuf_occupancy.sv | 55 +++++
 rtl/anita_event_buffer_sched.sv | 109 ++++++++++
 4 files changed

// File: rtl/anita_evbuf_pkg.sv
// rtl/anita_evbuf_pkg.sv - sizing constants and FSM encoding for the event buffer scheduler
package anita_evbuf_pkg;

    localparam int NBUF      = 4;
    localparam int NBUF_BITS = 2;
    localparam int WORDS     = 64;
    localparam int WORD_BITS = 6;
    localparam int DAT_BITS  = 16;
    localparam int ADDR_BITS = NBUF_BITS + WORD_BITS;
    localparam int CNT_BITS  = NBUF_BITS + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/anita_event_buffer_sched_if.sv
// rtl/anita_event_buffer_sched_if.sv - capture/readout handshake bundle for the event buffer scheduler
interface anita_event_buffer_sched_if;
    import anita_evbuf_pkg::*;

    logic                  evt_start;
    logic [DAT_BITS-1:0]   evt_dat;
    logic                  evt_dat_valid;
    logic                  clear_evt;
    logic [ADDR_BITS-1:0]  event_wr_addr;
    logic [DAT_BITS-1:0]   event_wr_dat;
    logic                  event_wr;
    logic                  event_done;
    logic [NBUF_BITS-1:0]  read_buffer;
    logic                  read_valid;
    logic [NBUF-1:0]       buffer_active;
    logic [CNT_BITS-1:0]   evt_count;
    logic                  evt_busy;
    logic                  evt_full;
    logic                  evt_drop;

    modport master (
        output evt_start, evt_dat, evt_dat_valid, clear_evt,
        input  event_wr_addr, event_wr_dat, event_wr, event_done, read_buffer, read_valid,
               buffer_active, evt_count, evt_busy, evt_full, evt_drop
    );

    modport slave (
        input  evt_start, evt_dat, evt_dat_valid, clear_evt,
        output event_wr_addr, event_wr_dat, event_wr, event_done, read_buffer, read_valid,
               buffer_active, evt_count, evt_busy, evt_full, evt_drop
    );

endinterface

// File: rtl/anita_evbuf_occupancy.sv
// rtl/anita_evbuf_occupancy.sv - buffer occupancy bits, write/read pointers and event count
module anita_evbuf_occupancy
    import anita_evbuf_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set,
    input  logic                 clr,
    output logic [NBUF-1:0]      active,
    output logic [NBUF_BITS-1:0] wr_buf,
    output logic [NBUF_BITS-1:0] rd_buf,
    output logic [CNT_BITS-1:0]  count,
    output logic                 full
);

    logic                clr_ok;
    logic [NBUF-1:0]     active_nxt;
    logic [CNT_BITS-1:0] count_nxt;

    // A clear only counts when the read buffer really holds an event.
    assign clr_ok = clr & active[rd_buf];

    always_comb begin
        active_nxt = active;
        count_nxt  = count;
        if (set)
            active_nxt[wr_buf] = 1'b1;
        if (clr_ok)
            active_nxt[rd_buf] = 1'b0;
        case ({set, clr_ok})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= '0;
            wr_buf <= '0;
            rd_buf <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            active <= active_nxt;
            count  <= count_nxt;
            full   <= (count_nxt == CNT_BITS'(NBUF));
            if (set)
                wr_buf <= wr_buf + 1'b1;
            if (clr_ok)
                rd_buf <= rd_buf + 1'b1;
        end
    end

endmodule

// File: rtl/anita_event_buffer_sched.sv
// rtl/anita_event_buffer_sched.sv - write-side scheduler: allocates buffers and sequences event word writes
module anita_event_buffer_sched
    import anita_evbuf_pkg::*;
(
    input  logic                        clk33,
    input  logic                        rst,
    anita_event_buffer_sched_if.slave   bus
);

    state_t                state, state_nxt;
    logic [WORD_BITS-1:0]  wr_word, wr_word_nxt;
    logic [ADDR_BITS-1:0]  wr_addr, wr_addr_nxt;
    logic [DAT_BITS-1:0]   wr_dat, wr_dat_nxt;
    logic                  wr_en, wr_en_nxt;
    logic                  done, done_nxt;
    logic                  drop, drop_nxt;
    logic                  alloc_block;

    logic [NBUF-1:0]       active;
    logic [NBUF_BITS-1:0]  wr_buf, rd_buf;
    logic [CNT_BITS-1:0]   count;
    logic                  full;

    anita_evbuf_occupancy u_occupancy (
        .clk    (clk33),
        .rst    (rst),
        .set    (done),
        .clr    (bus.clear_evt),
        .active (active),
        .wr_buf (wr_buf),
        .rd_buf (rd_buf),
        .count  (count),
        .full   (full)
    );

    // While the done pulse is out the occupancy has not yet counted the new event,
    // so a start in that cycle must not slip into the last free buffer twice.
    assign alloc_block = full | (done & (count == CNT_BITS'(NBUF - 1)));

    always_comb begin
        state_nxt   = state;
        wr_word_nxt = wr_word;
        wr_addr_nxt = wr_addr;
        wr_dat_nxt  = wr_dat;
        wr_en_nxt   = 1'b0;
        done_nxt    = 1'b0;
        drop_nxt    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.evt_start) begin
                    if (alloc_block) begin
                        drop_nxt = 1'b1;
                    end else begin
                        state_nxt   = ST_WRITE;
                        wr_word_nxt = '0;
                    end
                end
            end
            ST_WRITE: begin
                if (bus.evt_dat_valid) begin
                    wr_en_nxt   = 1'b1;
                    wr_addr_nxt = {wr_buf, wr_word};
                    wr_dat_nxt  = bus.evt_dat;
                    wr_word_nxt = wr_word + 1'b1;
                    if (wr_word == WORD_BITS'(WORDS - 1))
                        state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done_nxt  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk33 or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            wr_word <= '0;
            wr_addr <= '0;
            wr_dat  <= '0;
            wr_en   <= 1'b0;
            done    <= 1'b0;
            drop    <= 1'b0;
        end else begin
            state   <= state_nxt;
            wr_word <= wr_word_nxt;
            wr_addr <= wr_addr_nxt;
            wr_dat  <= wr_dat_nxt;
            wr_en   <= wr_en_nxt;
            done    <= done_nxt;
            drop    <= drop_nxt;
        end
    end

    assign bus.event_wr_addr = wr_addr;
    assign bus.event_wr_dat  = wr_dat;
    assign bus.event_wr      = wr_en;
    assign bus.event_done    = done;
    assign bus.evt_drop      = drop;
    assign bus.read_buffer   = rd_buf;
    assign bus.read_valid    = active[rd_buf];
    assign bus.buffer_active = active;
    assign bus.evt_count     = count;
    assign bus.evt_full      = full;
    assign bus.evt_busy      = (state != ST_IDLE);

endmodule
